alu_sequencer: RTL and testbench

Initiator for the 8-bit ALU operand/command interface. It accepts ALU requests over a valid/ready port and buffers them in a small FIFO. For each request it drives operands, command and output-enable to the ALU, samples the ALU's 16-bit tri-state result bus, and returns the result over a valid/ready response port. It sits between a control/test master and the combinational ALU.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_req_fifo.sv | 46 ++++
 rtl/alu_sequencer.sv | 143 ++++++++++++++
 tb/tb_alu_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: command codes, FSM states, entry width.
package alu_pkg;

  typedef enum logic [3:0] {
    ADD  = 4'd0,
    INC  = 4'd1,
    SUB  = 4'd2,
    DEC  = 4'd3,
    MUL  = 4'd4,
    DIV  = 4'd5,
    SHL  = 4'd6,
    SHR  = 4'd7,
    AND  = 4'd8,
    OR   = 4'd9,
    INV  = 4'd10,
    NAND = 4'd11,
    NOR  = 4'd12,
    XOR  = 4'd13,
    XNOR = 4'd14,
    BUF  = 4'd15
  } alu_cmd_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    DRIVE = 2'd2,
    RESP  = 2'd3
  } seq_state_e;

  // Request entry layout: {cmd[19:16], a[15:8], b[7:0]}
  localparam int unsigned REQ_W = 20;

endpackage

// File: rtl/alu_req_fifo.sv
// Synchronous request FIFO; pointers carry an extra wrap bit to tell full from empty.
module alu_req_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 20
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem[rd_q[AW-1:0]];

  // Pointer update; push and pop in the same cycle both advance
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_q <= rd_q + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/alu_sequencer.sv
// Sequences buffered requests onto the combinational ALU and returns captured results.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_cmd,
  input  logic [7:0]  req_a,
  input  logic [7:0]  req_b,
  output logic [7:0]  alu_a_in,
  output logic [7:0]  alu_b_in,
  output logic [3:0]  alu_command_in,
  output logic        alu_oe,
  input  logic [15:0] alu_d_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic [3:0]  rsp_cmd,
  output logic        rsp_err,
  output logic        busy
);

  seq_state_e       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [7:0]       a_q, b_q;
  logic [3:0]       cmd_q;
  logic [3:0]       op_cmd_q;
  logic             rsp_valid_q;
  logic [15:0]      rsp_data_q;
  logic [3:0]       rsp_cmd_q;
  logic             rsp_err_q;

  logic             fifo_full, fifo_empty;
  logic             push, pop, capture;
  logic [REQ_W-1:0] head;

  assign req_ready = !reset && !fifo_full;
  assign push      = req_valid && req_ready;

  alu_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REQ_W)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (push),
    .wdata_i ({req_cmd, req_a, req_b}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign alu_a_in       = a_q;
  assign alu_b_in       = b_q;
  assign alu_command_in = cmd_q;
  assign alu_oe         = (state_q == DRIVE);
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign rsp_cmd        = rsp_cmd_q;
  assign rsp_err        = rsp_err_q;
  assign busy           = (state_q != IDLE) || !fifo_empty;

  // Next-state, FIFO pop and result-capture decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = PRIME;
        end
      end
      PRIME: begin
        state_d = DRIVE;
        cnt_d   = 4'(SETTLE_CYCLES - 1);
      end
      DRIVE: begin
        if (cnt_q == 4'd0) begin
          capture = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and settle counter
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ALU drive registers and response capture.
  // The command register is loaded inverted on pop so the PRIME cycle
  // presents ~cmd, then switches to the real command entering DRIVE.
  always_ff @(posedge clock) begin
    if (reset) begin
      a_q         <= '0;
      b_q         <= '0;
      cmd_q       <= '0;
      op_cmd_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_cmd_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (pop) begin
        op_cmd_q <= head[19:16];
        cmd_q    <= ~head[19:16];
        a_q      <= head[15:8];
        b_q      <= head[7:0];
      end
      if (state_q == PRIME) cmd_q <= op_cmd_q;
      if (capture) begin
        rsp_valid_q <= 1'b1;
        rsp_data_q  <= alu_d_out;
        rsp_cmd_q   <= op_cmd_q;
        rsp_err_q   <= (op_cmd_q == DIV) && (b_q == 8'h00);
      end
      if ((state_q == RESP) && rsp_ready) rsp_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: two instances (SETTLE_CYCLES 1 and 3) with ALU models.
module tb_alu_sequencer;
  import alu_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [15:0] data;
    logic        err;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  // DUT 1 signals (SETTLE_CYCLES=1)
  logic        req_valid1, req_ready1, rsp_ready1, rsp_valid1, oe1, rsp_err1, busy1;
  logic [3:0]  req_cmd1, cmd1, rsp_cmd1;
  logic [7:0]  req_a1, req_b1, a1, b1;
  logic [15:0] d1, rsp_data1;
  // DUT 2 signals (SETTLE_CYCLES=3)
  logic        req_valid2, req_ready2, rsp_ready2, rsp_valid2, oe2, rsp_err2, busy2;
  logic [3:0]  req_cmd2, cmd2, rsp_cmd2;
  logic [7:0]  req_a2, req_b2, a2, b2;
  logic [15:0] d2, rsp_data2;

  alu_sequencer #(.DEPTH(4), .SETTLE_CYCLES(1)) dut1 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_cmd(req_cmd1),
    .req_a(req_a1), .req_b(req_b1),
    .alu_a_in(a1), .alu_b_in(b1), .alu_command_in(cmd1), .alu_oe(oe1),
    .alu_d_out(d1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_data(rsp_data1),
    .rsp_cmd(rsp_cmd1), .rsp_err(rsp_err1), .busy(busy1)
  );

  alu_sequencer #(.DEPTH(4), .SETTLE_CYCLES(3)) dut2 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid2), .req_ready(req_ready2), .req_cmd(req_cmd2),
    .req_a(req_a2), .req_b(req_b2),
    .alu_a_in(a2), .alu_b_in(b2), .alu_command_in(cmd2), .alu_oe(oe2),
    .alu_d_out(d2),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_data(rsp_data2),
    .rsp_cmd(rsp_cmd2), .rsp_err(rsp_err2), .busy(busy2)
  );

  function automatic logic [15:0] alu_f(logic [3:0] c, logic [7:0] a, logic [7:0] b);
    case (c)
      ADD:     alu_f = {8'h00, a} + {8'h00, b};
      SUB:     alu_f = {8'h00, a} - {8'h00, b};
      MUL:     alu_f = {8'h00, a} * {8'h00, b};
      DIV:     alu_f = (b == 8'h00) ? 16'hFFFF : {8'h00, a / b};
      default: alu_f = {a, b};
    endcase
  endfunction

  // ALU 1: plain combinational model, zero when not enabled
  assign d1 = oe1 ? alu_f(cmd1, a1, b1) : 16'h0000;

  // ALU 2: result only valid in the third enabled cycle, garbage before it
  int run2 = 0;
  always @(posedge clock) run2 <= oe2 ? run2 + 1 : 0;
  assign d2 = !oe2 ? 16'h0000 : (run2 == 2) ? alu_f(cmd2, a2, b2) : 16'hDEAD;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Response monitors: pop expected entry on each handshake
  int rsp_cnt1 = 0;
  always @(negedge clock) begin
    exp_t e;
    if (!reset && rsp_valid1 && rsp_ready1) begin
      rsp_cnt1++;
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL d1_unexpected_rsp: got data %0h with no request pending", rsp_data1);
      end else begin
        e = q1.pop_front();
        chk("d1_rsp_data", rsp_data1, e.data);
        chk("d1_rsp_cmd",  rsp_cmd1,  e.cmd);
        chk("d1_rsp_err",  rsp_err1,  e.err);
      end
    end
  end

  always @(negedge clock) begin
    exp_t e;
    if (!reset && rsp_valid2 && rsp_ready2) begin
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL d2_unexpected_rsp: got data %0h with no request pending", rsp_data2);
      end else begin
        e = q2.pop_front();
        chk("d2_rsp_data", rsp_data2, e.data);
        chk("d2_rsp_cmd",  rsp_cmd2,  e.cmd);
        chk("d2_rsp_err",  rsp_err2,  e.err);
      end
    end
  end

  // Drive-phase monitors: inverted command before oe rises, oe pulse width
  logic       poe1 = 1'b0, poe2 = 1'b0, skip_oe2 = 1'b0;
  logic [3:0] pcmd1 = '0, pcmd2 = '0, inv1, inv2;
  int         len1 = 0, len2 = 0;
  always @(negedge clock) begin
    inv1 = ~cmd1;
    if (oe1 && !poe1) begin
      chk("d1_prime_cmd", pcmd1, inv1);
      if (q1.size() > 0) chk("d1_drive_cmd", cmd1, q1[0].cmd);
    end
    if (oe1) len1++;
    else if (len1 != 0) begin
      chk("d1_oe_len", len1, 1);
      len1 = 0;
    end
    poe1  = oe1;
    pcmd1 = cmd1;
  end

  always @(negedge clock) begin
    inv2 = ~cmd2;
    if (oe2 && !poe2) begin
      chk("d2_prime_cmd", pcmd2, inv2);
      if (q2.size() > 0) chk("d2_drive_cmd", cmd2, q2[0].cmd);
    end
    if (oe2) len2++;
    else if (len2 != 0) begin
      if (!skip_oe2) chk("d2_oe_len", len2, 3);
      len2 = 0;
    end
    poe2  = oe2;
    pcmd2 = cmd2;
  end

  task automatic send1(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b,
                       input exp_t e, output int acc);
    acc = -1;
    req_valid1 = 1'b1; req_cmd1 = c; req_a1 = a; req_b1 = b;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (req_ready1) begin
        q1.push_back(e);
        acc = cyc;
        break;
      end
      @(posedge clock); #1;
    end
    if (acc < 0) begin
      checks++; errors++;
      $display("FAIL d1_send_timeout: req_ready stayed %0d, required 1", req_ready1);
    end else begin
      @(posedge clock); #1;
    end
    req_valid1 = 1'b0;
  endtask

  task automatic send2(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b,
                       input exp_t e);
    bit ok = 1'b0;
    req_valid2 = 1'b1; req_cmd2 = c; req_a2 = a; req_b2 = b;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (req_ready2) begin
        q2.push_back(e);
        ok = 1'b1;
        break;
      end
      @(posedge clock); #1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL d2_send_timeout: req_ready stayed %0d, required 1", req_ready2);
    end else begin
      @(posedge clock); #1;
    end
    req_valid2 = 1'b0;
  endtask

  task automatic wait_idle1();
    int i;
    for (i = 0; i < 100; i++) begin
      @(posedge clock); #1;
      if (!busy1 && !rsp_valid1 && q1.size() == 0) break;
    end
    chk("d1_drain_pending", q1.size(), 0);
  endtask

  task automatic wait_idle2();
    int i;
    for (i = 0; i < 100; i++) begin
      @(posedge clock); #1;
      if (!busy2 && !rsp_valid2 && q2.size() == 0) break;
    end
    chk("d2_drain_pending", q2.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, acc, stall, base, got;
    reset = 1'b1;
    req_valid1 = 0; req_cmd1 = '0; req_a1 = '0; req_b1 = '0; rsp_ready1 = 1'b1;
    req_valid2 = 0; req_cmd2 = '0; req_a2 = '0; req_b2 = '0; rsp_ready2 = 1'b1;

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_req_ready1", req_ready1, 0);
    chk("rst_req_ready2", req_ready2, 0);
    chk("rst_oe1",        oe1, 0);
    chk("rst_rsp_valid1", rsp_valid1, 0);
    chk("rst_busy1",      busy1, 0);
    chk("rst_alu_bus1",   {a1, b1, cmd1}, 0);
    chk("rst_rsp1",       {rsp_data1, rsp_cmd1, rsp_err1}, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_ready1", req_ready1, 1);
    @(posedge clock); #1;

    // 1: single ADD and latency
    send1(ADD, 8'h0F, 8'h01, '{cmd: ADD, data: 16'h0010, err: 1'b0}, t);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (rsp_valid1) begin got = cyc; break; end
    end
    chk("t1_latency", got, t + 4);
    wait_idle1();

    // 2: back-to-back MUL
    send1(MUL, 8'h03, 8'h04, '{cmd: MUL, data: 16'h000C, err: 1'b0}, t);
    send1(MUL, 8'h05, 8'h06, '{cmd: MUL, data: 16'h001E, err: 1'b0}, t);
    wait_idle1();

    // 3: divide by zero, then a normal divide
    send1(DIV, 8'h10, 8'h00, '{cmd: DIV, data: 16'hFFFF, err: 1'b1}, t);
    send1(DIV, 8'h10, 8'h04, '{cmd: DIV, data: 16'h0004, err: 1'b0}, t);
    wait_idle1();

    // 4: backpressure fills the FIFO
    rsp_ready1 = 1'b0;
    base  = rsp_cnt1;
    acc   = 0;
    stall = 0;
    req_valid1 = 1'b1;
    for (int i = 0; i < 40; i++) begin
      req_cmd1 = ADD; req_a1 = 8'(acc + 1); req_b1 = 8'(acc + 1);
      @(negedge clock);
      if (req_ready1) begin
        q1.push_back('{cmd: ADD, data: 16'(2 * (acc + 1)), err: 1'b0});
        acc++;
        stall = 0;
      end else begin
        stall++;
      end
      @(posedge clock); #1;
      if (stall >= 6) break;
    end
    req_valid1 = 1'b0;
    chk("t4_accepted", acc, 5);
    @(negedge clock);
    chk("t4_full_ready", req_ready1, 0);
    chk("t4_rsp_waiting", rsp_valid1, 1);
    @(posedge clock); #1;
    rsp_ready1 = 1'b1;
    got = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (req_ready1) begin got = 1; break; end
    end
    chk("t4_ready_back", got, 1);
    wait_idle1();
    chk("t4_rsp_count", rsp_cnt1 - base, 5);

    // 5: SETTLE_CYCLES=3 samples in the last drive cycle
    send2(ADD, 8'h20, 8'h22, '{cmd: ADD, data: 16'h0042, err: 1'b0});
    send2(SUB, 8'h50, 8'h10, '{cmd: SUB, data: 16'h0040, err: 1'b0});
    wait_idle2();

    // 6: reset in DRIVE with two requests queued
    skip_oe2 = 1'b1;
    send2(ADD, 8'h01, 8'h01, '{cmd: ADD, data: 16'h0002, err: 1'b0});
    send2(ADD, 8'h02, 8'h02, '{cmd: ADD, data: 16'h0004, err: 1'b0});
    send2(ADD, 8'h03, 8'h03, '{cmd: ADD, data: 16'h0006, err: 1'b0});
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (oe2) begin got = 1; break; end
    end
    chk("t6_reached_drive", got, 1);
    chk("t6_queued_busy", busy2, 1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    q2.delete();
    @(negedge clock);
    chk("t6_oe",        oe2, 0);
    chk("t6_rsp_valid", rsp_valid2, 0);
    chk("t6_busy",      busy2, 0);
    chk("t6_req_ready", req_ready2, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("t6_no_stale_rsp", {rsp_valid2, busy2, oe2}, 0);
    end
    skip_oe2 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
